// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: default width, opcode encodings, FSM states.
package calc_pkg;

   localparam int unsigned DataWDefault = 4;

   // Opcodes with a trailing don't-care bit are listed with that bit cleared.
   localparam logic [2:0] OP_ADD_AB = 3'b000;
   localparam logic [2:0] OP_SUB_AB = 3'b001;
   localparam logic [2:0] OP_ABS_B  = 3'b010;
   localparam logic [2:0] OP_ADD_BA = 3'b100;
   localparam logic [2:0] OP_SUB_BA = 3'b101;
   localparam logic [2:0] OP_ABS_A  = 3'b110;

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StResp
   } state_e;

endpackage

// File: rtl/calc_settle_cnt.sv
// Loadable down-counter that stops at zero; zero_o marks the end of the settle window.
module calc_settle_cnt #(
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/calc_op_issuer.sv
// Sequential front end for the combinational calculator: accepts a command, holds the calculator
// inputs for SETTLE cycles, captures the result and returns it on a response handshake.
module calc_op_issuer
   import calc_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [2:0]        cmd_op_i,
   input  logic [DATA_W-1:0] cmd_a_i,
   input  logic [DATA_W-1:0] cmd_b_i,
   input  logic              cmd_chain_i,
   output logic [2:0]        calc_op_o,
   output logic [DATA_W-1:0] calc_a_o,
   output logic [DATA_W-1:0] calc_b_o,
   input  logic [DATA_W-1:0] calc_r_i,
   input  logic              calc_ovf_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_r_o,
   output logic              rsp_ovf_o,
   output logic [DATA_W-1:0] acc_o,
   output logic              sticky_ovf_o,
   input  logic              clr_sticky_i,
   output logic [CNT_W-1:0]  op_count_o
);

   localparam int unsigned SettleW = $clog2(SETTLE + 1);

   if (SETTLE == 0) begin : gen_settle_zero
      $fatal(1, "calc_op_issuer: SETTLE must be at least 1");
   end

   state_e state_d, state_q;

   logic [2:0]        calc_op_q;
   logic [DATA_W-1:0] calc_a_q, calc_b_q;
   logic [DATA_W-1:0] rsp_r_q, acc_q;
   logic              rsp_ovf_q;
   logic              sticky_d, sticky_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              accept, capture, settle_zero;

   assign accept  = cmd_valid_i && (state_q == StIdle);
   assign capture = (state_q == StDrive) && settle_zero;

   calc_settle_cnt #(
      .Width (SettleW)
   ) u_settle_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (accept),
      .load_val_i (SettleW'(SETTLE - 1)),
      .zero_o     (settle_zero)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StDrive;
         StDrive: if (settle_zero) state_d = StResp;
         StResp:  if (rsp_ready_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A capture overflow on the same edge as a clear keeps the flag set.
   always_comb begin
      sticky_d = sticky_q;
      if (clr_sticky_i) sticky_d = 1'b0;
      if (capture && calc_ovf_i) sticky_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         calc_op_q <= '0;
         calc_a_q  <= '0;
         calc_b_q  <= '0;
         rsp_r_q   <= '0;
         rsp_ovf_q <= 1'b0;
         acc_q     <= '0;
         sticky_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q  <= state_d;
         sticky_q <= sticky_d;
         if (accept) begin
            calc_op_q <= cmd_op_i;
            calc_a_q  <= cmd_chain_i ? acc_q : cmd_a_i;
            calc_b_q  <= cmd_b_i;
         end
         if (capture) begin
            rsp_r_q   <= calc_r_i;
            rsp_ovf_q <= calc_ovf_i;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (!calc_ovf_i) acc_q <= calc_r_i;
         end
      end
   end

   assign cmd_ready_o  = (state_q == StIdle);
   assign rsp_valid_o  = (state_q == StResp);
   assign calc_op_o    = calc_op_q;
   assign calc_a_o     = calc_a_q;
   assign calc_b_o     = calc_b_q;
   assign rsp_r_o      = rsp_r_q;
   assign rsp_ovf_o    = rsp_ovf_q;
   assign acc_o        = acc_q;
   assign sticky_ovf_o = sticky_q;
   assign op_count_o   = cnt_q;

endmodule

// File: tb/tb_calc_op_issuer.sv
// Bench: two issuers (SETTLE=1 and SETTLE=3), each wired to a behavioural 4-bit signed calculator.
module tb_calc_op_issuer;

   logic       clk;
   logic       rst_n[2];
   logic       cmd_valid[2], cmd_ready[2], cmd_chain[2];
   logic [2:0] cmd_op[2], calc_op[2];
   logic [3:0] cmd_a[2], cmd_b[2], calc_a[2], calc_b[2], calc_r[2];
   logic       calc_ovf[2], rsp_valid[2], rsp_ready[2], rsp_ovf[2], sticky[2], clr[2];
   logic [3:0] rsp_r[2], acc[2];
   logic [7:0] op_count[2];

   int n_err = 0;
   int n_chk = 0;
   int settle[2] = '{1, 3};

   logic [3:0] m_acc[2];
   logic       m_sticky[2];
   int         m_cnt[2];

   // Calculator: signed 4-bit, ovf when the true result leaves [-8, 7].
   function automatic logic [4:0] calc_f(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
      int sa, sb, res;
      sa = int'($signed(a));
      sb = int'($signed(b));
      casez (op)
         3'b000:  res = sa + sb;
         3'b001:  res = sa - sb;
         3'b01?:  res = (sb < 0) ? -sb : sb;
         3'b100:  res = sb + sa;
         3'b101:  res = sb - sa;
         default: res = (sa < 0) ? -sa : sa;
      endcase
      return {(res > 7) || (res < -8), res[3:0]};
   endfunction

   assign {calc_ovf[0], calc_r[0]} = calc_f(calc_op[0], calc_a[0], calc_b[0]);
   assign {calc_ovf[1], calc_r[1]} = calc_f(calc_op[1], calc_a[1], calc_b[1]);

   calc_op_issuer #(.DATA_W(4), .SETTLE(1), .CNT_W(8)) dut1 (
      .clk_i(clk), .rst_ni(rst_n[0]), .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
      .cmd_op_i(cmd_op[0]), .cmd_a_i(cmd_a[0]), .cmd_b_i(cmd_b[0]), .cmd_chain_i(cmd_chain[0]),
      .calc_op_o(calc_op[0]), .calc_a_o(calc_a[0]), .calc_b_o(calc_b[0]), .calc_r_i(calc_r[0]),
      .calc_ovf_i(calc_ovf[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
      .rsp_r_o(rsp_r[0]), .rsp_ovf_o(rsp_ovf[0]), .acc_o(acc[0]), .sticky_ovf_o(sticky[0]),
      .clr_sticky_i(clr[0]), .op_count_o(op_count[0])
   );

   calc_op_issuer #(.DATA_W(4), .SETTLE(3), .CNT_W(8)) dut3 (
      .clk_i(clk), .rst_ni(rst_n[1]), .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
      .cmd_op_i(cmd_op[1]), .cmd_a_i(cmd_a[1]), .cmd_b_i(cmd_b[1]), .cmd_chain_i(cmd_chain[1]),
      .calc_op_o(calc_op[1]), .calc_a_o(calc_a[1]), .calc_b_o(calc_b[1]), .calc_r_i(calc_r[1]),
      .calc_ovf_i(calc_ovf[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
      .rsp_r_o(rsp_r[1]), .rsp_ovf_o(rsp_ovf[1]), .acc_o(acc[1]), .sticky_ovf_o(sticky[1]),
      .clr_sticky_i(clr[1]), .op_count_o(op_count[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset(input int idx);
      m_acc[idx]    = '0;
      m_sticky[idx] = 1'b0;
      m_cnt[idx]    = 0;
   endtask

   task automatic chk_state(input int idx, input string tag);
      chk({tag, "_acc"}, acc[idx], m_acc[idx]);
      chk({tag, "_sticky"}, sticky[idx], m_sticky[idx]);
      chk({tag, "_op_count"}, op_count[idx], m_cnt[idx] % 256);
   endtask

   // Called at a negedge; returns at the negedge of the first RESP cycle with rsp_ready low.
   task automatic start(input int idx, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic chain, input logic clr_at_cap);
      int lat, to;
      logic [3:0] ea;
      logic [4:0] res;
      cmd_op[idx]    = op;
      cmd_a[idx]     = a;
      cmd_b[idx]     = b;
      cmd_chain[idx] = chain;
      cmd_valid[idx] = 1'b1;
      to = 0;
      while (!cmd_ready[idx] && to < 50) begin
         @(negedge clk);
         to++;
      end
      chk("accept_wait", 32'(to < 50), 1);
      ea  = chain ? m_acc[idx] : a;
      res = calc_f(op, ea, b);
      @(negedge clk);
      cmd_valid[idx] = 1'b0;
      chk("calc_op", calc_op[idx], op);
      chk("calc_a", calc_a[idx], ea);
      chk("calc_b", calc_b[idx], b);
      lat = 1;
      while (!rsp_valid[idx] && lat < 20) begin
         clr[idx] = (lat == settle[idx]) && clr_at_cap;
         @(negedge clk);
         lat++;
      end
      clr[idx] = 1'b0;
      chk("rsp_latency", lat, settle[idx] + 1);
      chk("rsp_r", rsp_r[idx], res[3:0]);
      chk("rsp_ovf", rsp_ovf[idx], res[4]);
      m_cnt[idx] = (m_cnt[idx] + 1) % 256;
      if (!res[4]) m_acc[idx] = res[3:0];
      if (res[4]) m_sticky[idx] = 1'b1;
      else if (clr_at_cap) m_sticky[idx] = 1'b0;
      chk_state(idx, "rsp");
   endtask

   task automatic finish_rsp(input int idx);
      rsp_ready[idx] = 1'b1;
      @(negedge clk);
      rsp_ready[idx] = 1'b0;
      chk("rsp_valid_drop", rsp_valid[idx], 0);
      chk("cmd_ready_back", cmd_ready[idx], 1);
   endtask

   task automatic rand_op(input int idx);
      int dly;
      start(idx, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      dly = $urandom_range(0, 2);
      for (int k = 0; k < dly; k++) begin
         @(negedge clk);
         chk("rsp_hold_valid", rsp_valid[idx], 1);
      end
      finish_rsp(idx);
   endtask

   task automatic chk_reset_outputs(input int idx);
      chk("rst_calc_op", calc_op[idx], 0);
      chk("rst_calc_a", calc_a[idx], 0);
      chk("rst_calc_b", calc_b[idx], 0);
      chk("rst_rsp_valid", rsp_valid[idx], 0);
      chk("rst_rsp_r", rsp_r[idx], 0);
      chk("rst_rsp_ovf", rsp_ovf[idx], 0);
      chk("rst_acc", acc[idx], 0);
      chk("rst_sticky", sticky[idx], 0);
      chk("rst_op_count", op_count[idx], 0);
   endtask

   typedef struct {
      logic [2:0] op;
      logic [3:0] a, b;
      logic       chain, clr, pre_clr;
      logic [3:0] e_calc_a, e_r;
      logic       e_ovf;
      logic [3:0] e_acc;
      logic       e_sticky;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [3:0] held_r, held_a;

      tbl[0] = '{3'b000, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 4'd7, 1'b0, 8'd1};
      tbl[1] = '{3'b000, 4'd7, 4'd1, 1'b0, 1'b1, 1'b0, 4'd7, 4'h8, 1'b1, 4'd7, 1'b1, 8'd2};
      tbl[2] = '{3'b001, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 4'd7, 4'd5, 1'b0, 4'd5, 1'b1, 8'd3};
      tbl[3] = '{3'b110, 4'h8, 4'd0, 1'b0, 1'b0, 1'b0, 4'h8, 4'h8, 1'b1, 4'd5, 1'b1, 8'd4};
      tbl[4] = '{3'b101, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1, 4'd5, 4'hC, 1'b0, 4'hC, 1'b0, 8'd5};
      tbl[5] = '{3'b010, 4'd0, 4'hD, 1'b1, 1'b0, 1'b0, 4'hC, 4'd3, 1'b0, 4'd3, 1'b0, 8'd6};

      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_op[i] = '0; cmd_a[i] = '0; cmd_b[i] = '0;
         cmd_chain[i] = 1'b0; rsp_ready[i] = 1'b0; clr[i] = 1'b0;
         model_reset(i);
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk_reset_outputs(i);
         rst_n[i] = 1'b1;
      end
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready[0], 1);

      // Directed vectors on the SETTLE=1 issuer.
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].pre_clr) begin
            clr[0] = 1'b1;
            @(negedge clk);
            clr[0] = 1'b0;
            m_sticky[0] = 1'b0;
            chk("sticky_clear", sticky[0], 0);
         end
         start(0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].chain, tbl[i].clr);
         chk("tbl_calc_a", calc_a[0], tbl[i].e_calc_a);
         chk("tbl_rsp_r", rsp_r[0], tbl[i].e_r);
         chk("tbl_rsp_ovf", rsp_ovf[0], tbl[i].e_ovf);
         chk("tbl_acc", acc[0], tbl[i].e_acc);
         chk("tbl_sticky", sticky[0], tbl[i].e_sticky);
         chk("tbl_op_count", op_count[0], tbl[i].e_cnt);
         finish_rsp(0);
      end

      // Response back-pressure with a second command waiting.
      start(0, 3'b000, 4'd2, 4'd3, 1'b0, 1'b0);
      held_r = rsp_r[0];
      held_a = calc_a[0];
      cmd_op[0] = 3'b001; cmd_a[0] = 4'd6; cmd_b[0] = 4'd1; cmd_chain[0] = 1'b0;
      cmd_valid[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid[0], 1);
         chk("bp_rsp_r", rsp_r[0], held_r);
         chk("bp_cmd_ready", cmd_ready[0], 0);
         chk("bp_calc_a", calc_a[0], held_a);
      end
      finish_rsp(0);
      chk("bp_not_yet_accepted", calc_a[0], held_a);
      start(0, 3'b001, 4'd6, 4'd1, 1'b0, 1'b0);
      finish_rsp(0);

      for (int n = 0; n < 40; n++) rand_op(0);

      // Reset in the middle of DRIVE abandons the op.
      start(0, 3'b000, 4'd7, 4'd1, 1'b0, 1'b0);
      finish_rsp(0);
      cmd_op[0] = 3'b000; cmd_a[0] = 4'd1; cmd_b[0] = 4'd1; cmd_chain[0] = 1'b0;
      cmd_valid[0] = 1'b1;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      rst_n[0] = 1'b0;
      repeat (2) @(negedge clk);
      model_reset(0);
      chk_reset_outputs(0);
      rst_n[0] = 1'b1;
      chk("rst_cmd_ready", cmd_ready[0], 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_no_rsp", rsp_valid[0], 0);
      end

      // SETTLE=3 issuer: run the op counter up to 255, then wrap.
      for (int n = 0; n < 255; n++) rand_op(1);
      chk("cnt_255", op_count[1], 8'd255);
      start(1, 3'b000, 4'd1, 4'd2, 1'b0, 1'b0);
      chk("cnt_wrap", op_count[1], 0);
      finish_rsp(1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
